// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: bus word, RAM handshake state and the memory arbiter's grant state.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DGRANT  = 2'd1,
    IGRANT0 = 2'd2,
    IGRANT1 = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the requesters (data bus controller, two fetch ports), the arbiter and the RAM.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic            dramREN;
  logic            dramWEN;
  word_t           dramaddr;
  word_t           dramstore;
  word_t           dramload;
  logic            ramwait;

  logic [1:0]      iREN;
  word_t [1:0]     iaddr;
  word_t           iload;
  logic [1:0]      iwait;

  logic            ramREN;
  logic            ramWEN;
  word_t           ramaddr;
  word_t           ramstore;
  word_t           ramload;
  ramstate_t       ramstate;

  // The arbiter serves requests and owns the RAM request lines.
  modport slave (
    input  dramREN, dramWEN, dramaddr, dramstore, iREN, iaddr, ramload, ramstate,
    output dramload, ramwait, iload, iwait, ramREN, ramWEN, ramaddr, ramstore
  );

  // Requesters and RAM together, as seen from the environment.
  modport master (
    output dramREN, dramWEN, dramaddr, dramstore, iREN, iaddr, ramload, ramstate,
    input  dramload, ramwait, iload, iwait, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data traffic first, bounded by a starvation guard; fetch ports round-robin.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);

  localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t        state, next_state;
  logic [CNT_W-1:0]  starve_cnt, next_cnt;
  logic              last_icore, next_last;
  logic              dreq, ireq_any, granted_req, done;

  assign dreq     = bus.dramREN | bus.dramWEN;
  assign ireq_any = |bus.iREN;

  assign bus.dramload = bus.ramload;
  assign bus.iload    = bus.ramload;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the case infers a latch.
    next_state   = state;
    next_cnt     = starve_cnt;
    next_last    = last_icore;
    granted_req  = 1'b0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.ramwait  = 1'b1;
    bus.iwait    = 2'b11;

    unique case (state)
      IDLE: begin
        if (dreq && (starve_cnt < CNT_MAX)) begin
          next_state = DGRANT;
        end else if (bus.iREN == 2'b11) begin
          next_state = last_icore ? IGRANT0 : IGRANT1;
        end else if (bus.iREN[0]) begin
          next_state = IGRANT0;
        end else if (bus.iREN[1]) begin
          next_state = IGRANT1;
        end
      end
      DGRANT: begin
        // A write beats a simultaneous read.
        bus.ramWEN   = bus.dramWEN;
        bus.ramREN   = bus.dramREN & ~bus.dramWEN;
        bus.ramaddr  = bus.dramaddr;
        bus.ramstore = bus.dramstore;
        granted_req  = dreq;
      end
      IGRANT0: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr[0];
        granted_req = bus.iREN[0];
      end
      IGRANT1: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr[1];
        granted_req = bus.iREN[1];
      end
      default: next_state = IDLE;
    endcase

    done = granted_req && (bus.ramstate == ACCESS);

    // A requester that gives up mid-grant releases the RAM without completing.
    if ((state != IDLE) && !granted_req) begin
      next_state = IDLE;
    end

    if (done) begin
      next_state = IDLE;
      case (state)
        DGRANT: begin
          bus.ramwait = 1'b0;
          if (ireq_any && (starve_cnt < CNT_MAX)) begin
            next_cnt = starve_cnt + 1'b1;
          end
        end
        IGRANT0: begin
          bus.iwait[0] = 1'b0;
          next_cnt     = '0;
          next_last    = 1'b0;
        end
        IGRANT1: begin
          bus.iwait[1] = 1'b0;
          next_cnt     = '0;
          next_last    = 1'b1;
        end
        default: ;
      endcase
    end

    if (!ireq_any) begin
      next_cnt = '0;
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: RST is sampled on the clock edge like any other input; state uses <= so all registers see pre-edge values.
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      last_icore <= 1'b1;
    end else begin
      state      <= next_state;
      starve_cnt <= next_cnt;
      last_icore <= next_last;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic checked against a grant-ownership model of the arbiter.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int LIMIT  = 4;
  localparam int N_RAND = 2000;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [159:0] got, exp;

  // Reference model: who currently owns the RAM (0 none, 1 data, 2 core0, 3 core1).
  int m_owner, m_starve, m_last;

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.dramREN   = 1'b0;
    bus.dramWEN   = 1'b0;
    bus.dramaddr  = '0;
    bus.dramstore = '0;
    bus.iREN      = 2'b00;
    bus.iaddr[0]  = '0;
    bus.iaddr[1]  = '0;
    bus.ramload   = '0;
    bus.ramstate  = FREE;
  endtask

  task automatic model_reset();
    m_owner  = 0;
    m_starve = 0;
    m_last   = 1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    RST = 1'b0;
    model_reset();
  endtask

  function automatic logic [159:0] model_out();
    logic       rren, rwen, rwait;
    logic [1:0] iw;
    word_t      ra, rs;
    int         n;
    rren  = 1'b0;
    rwen  = 1'b0;
    rwait = 1'b1;
    iw    = 2'b11;
    ra    = '0;
    rs    = '0;
    if (m_owner == 1) begin
      rwen = bus.dramWEN;
      rren = bus.dramREN && !bus.dramWEN;
      ra   = bus.dramaddr;
      rs   = bus.dramstore;
      if ((bus.dramREN || bus.dramWEN) && bus.ramstate == ACCESS) rwait = 1'b0;
    end else if (m_owner >= 2) begin
      n    = m_owner - 2;
      rren = 1'b1;
      ra   = bus.iaddr[n];
      if (bus.iREN[n] && bus.ramstate == ACCESS) iw[n] = 1'b0;
    end
    return {rren, rwen, ra, rs, rwait, iw, bus.ramload, bus.ramload};
  endfunction

  task automatic model_step();
    bit anyi, dreq, req;
    anyi = (bus.iREN != 2'b00);
    dreq = bus.dramREN || bus.dramWEN;
    if (RST) begin
      model_reset();
      return;
    end
    if (m_owner == 0) begin
      if (dreq && m_starve < LIMIT)  m_owner = 1;
      else if (bus.iREN == 2'b11)    m_owner = (m_last == 1) ? 2 : 3;
      else if (bus.iREN[0])          m_owner = 2;
      else if (bus.iREN[1])          m_owner = 3;
    end else begin
      req = (m_owner == 1) ? dreq : bus.iREN[m_owner-2];
      if (!req) begin
        m_owner = 0;
      end else if (bus.ramstate == ACCESS) begin
        if (m_owner == 1) begin
          if (anyi) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
        end else begin
          m_starve = 0;
          m_last   = m_owner - 2;
        end
        m_owner = 0;
      end
    end
    if (!anyi) m_starve = 0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    settle();
    got = {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.ramwait, bus.iwait};
    exp = {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 2'b11};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL reset_outputs got=%h exp=%h", got, exp); end
    // Requests during reset must not produce a grant.
    bus.dramREN = 1'b1;
    bus.iREN    = 2'b11;
    next_cycle();
    settle();
    got = {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramwait, bus.iwait};
    exp = {1'b0, 1'b0, 32'h0, 1'b1, 2'b11};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL reset_holds got=%h exp=%h", got, exp); end
    do_reset();
  endtask

  task automatic test_data_read();
    do_reset();
    bus.dramREN  = 1'b1;
    bus.dramaddr = 32'h100;
    bus.ramload  = 32'hDEADBEEF;
    bus.ramstate = BUSY;
    settle();
    got = {bus.ramREN, bus.ramwait};
    exp = {1'b0, 1'b1};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL rd_cycle0 got=%h exp=%h", got, exp); end
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      settle();
      got = {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramwait};
      exp = {1'b1, 1'b0, 32'h100, 1'b1};
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL rd_busy_c%0d got=%h exp=%h", c, got, exp); end
    end
    next_cycle();
    bus.ramstate = ACCESS;
    settle();
    got = {bus.ramREN, bus.ramwait, bus.dramload};
    exp = {1'b1, 1'b0, 32'hDEADBEEF};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL rd_complete got=%h exp=%h", got, exp); end
    next_cycle();
    bus.dramREN  = 1'b0;
    bus.ramstate = FREE;
    settle();
    got = {bus.ramREN, bus.ramaddr, bus.ramwait};
    exp = {1'b0, 32'h0, 1'b1};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL rd_idle got=%h exp=%h", got, exp); end
  endtask

  task automatic test_data_priority();
    do_reset();
    bus.dramWEN   = 1'b1;
    bus.dramaddr  = 32'h200;
    bus.dramstore = 32'h5;
    bus.iREN      = 2'b01;
    bus.iaddr[0]  = 32'h40;
    bus.ramstate  = ACCESS;
    next_cycle();
    settle();
    got = {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.ramwait, bus.iwait};
    exp = {1'b0, 1'b1, 32'h200, 32'h5, 1'b0, 2'b11};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL prio_data got=%h exp=%h", got, exp); end
    next_cycle();
    bus.dramWEN = 1'b0;
    settle();
    got = {bus.ramREN, bus.ramWEN, bus.ramwait, bus.iwait};
    exp = {1'b0, 1'b0, 1'b1, 2'b11};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL prio_gap got=%h exp=%h", got, exp); end
    next_cycle();
    settle();
    got = {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.ramwait, bus.iwait};
    exp = {1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 2'b10};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL prio_inst got=%h exp=%h", got, exp); end
  endtask

  task automatic test_round_robin();
    logic [1:0] iw_tab [6];
    word_t      ad_tab [6];
    iw_tab = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11};
    ad_tab = '{32'h1000, 32'h0, 32'h2000, 32'h0, 32'h1000, 32'h0};
    do_reset();
    bus.iREN     = 2'b11;
    bus.iaddr[0] = 32'h1000;
    bus.iaddr[1] = 32'h2000;
    bus.ramstate = ACCESS;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      settle();
      got = {bus.iwait, bus.ramaddr};
      exp = {iw_tab[c], ad_tab[c]};
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL rr_c%0d got=%h exp=%h", c + 1, got, exp); end
    end
  endtask

  task automatic test_starvation();
    logic rw_tab [11];
    logic i1_tab [11];
    rw_tab = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    i1_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    bus.dramREN  = 1'b1;
    bus.dramaddr = 32'h300;
    bus.iREN     = 2'b10;
    bus.iaddr[1] = 32'h80;
    bus.ramstate = ACCESS;
    for (int c = 0; c < 11; c++) begin
      next_cycle();
      settle();
      got = {bus.ramwait, bus.iwait[1], bus.iwait[0]};
      exp = {rw_tab[c], i1_tab[c], 1'b1};
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL starve_c%0d got=%h exp=%h", c + 1, got, exp); end
    end
  endtask

  task automatic test_abandon_reset();
    do_reset();
    bus.dramREN  = 1'b1;
    bus.dramaddr = 32'h500;
    bus.ramstate = BUSY;
    next_cycle();
    settle();
    got = {bus.ramREN, bus.ramwait};
    exp = {1'b1, 1'b1};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL abandon_grant got=%h exp=%h", got, exp); end
    next_cycle();
    bus.dramREN = 1'b0;
    settle();
    got = {bus.ramwait};
    exp = {1'b1};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL abandon_drop got=%h exp=%h", got, exp); end
    next_cycle();
    bus.ramstate = ACCESS;
    settle();
    got = {bus.ramREN, bus.ramaddr, bus.ramwait};
    exp = {1'b0, 32'h0, 1'b1};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL abandon_idle got=%h exp=%h", got, exp); end

    do_reset();
    bus.iREN     = 2'b01;
    bus.iaddr[0] = 32'h44;
    bus.ramstate = BUSY;
    next_cycle();
    RST = 1'b1;
    settle();
    got = {bus.ramREN, bus.ramaddr, bus.iwait};
    exp = {1'b1, 32'h44, 2'b11};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL rst_mid_grant got=%h exp=%h", got, exp); end
    next_cycle();
    RST = 1'b0;
    bus.iREN = 2'b00;
    settle();
    got = {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.ramwait, bus.iwait};
    exp = {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 2'b11};
    n_vec++;
    if (got !== exp) begin n_err++; $display("FAIL rst_after got=%h exp=%h", got, exp); end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < N_RAND; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.dramREN = 1'($urandom_range(0, 1));
        bus.dramWEN = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 3) == 0) bus.iREN = 2'($urandom_range(0, 3));
      bus.dramaddr  = $urandom;
      bus.dramstore = $urandom;
      bus.iaddr[0]  = $urandom;
      bus.iaddr[1]  = $urandom;
      bus.ramload   = $urandom;
      r = $urandom_range(0, 9);
      bus.ramstate  = (r < 4) ? ACCESS : (r < 8) ? BUSY : (r == 8) ? FREE : ERROR;
      RST = ($urandom_range(0, 63) == 0);
      settle();
      got = {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.ramwait, bus.iwait,
             bus.dramload, bus.iload};
      exp = model_out();
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL rand_%0d got=%h exp=%h", i, got, exp); end
      model_step();
      next_cycle();
    end
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_data_read();
    test_data_priority();
    test_round_robin();
    test_starvation();
    test_abandon_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
